// File: rtl/mc_controller_if.sv
// ---------------------------------------------------------------------------
// mc_controller_if
//   Bundle of signals between the multicycle sequencer and the shared-ALU
//   datapath / single-port memory.
//   Inputs to the controller:
//     op[6:0]       instruction opcode (Instr[6:0])
//     funct3[2:0]   Instr[14:12]
//     funct7b5      Instr[30]
//     Zero          ALU zero flag
//     MemReady      memory accepted the write / returned data this cycle
//   Outputs from the controller:
//     PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc[1:0], ALUSrcA[1:0],
//     ALUSrcB[1:0], ImmSrc[1:0], ALUControl[2:0], RegWrite, IllegalInstr
//   Modports: slave = controller side, master = datapath side.
// ---------------------------------------------------------------------------
interface mc_controller_if;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       Zero;
   logic       MemReady;

   logic       PCWrite;
   logic       AdrSrc;
   logic       MemWrite;
   logic       IRWrite;
   logic [1:0] ResultSrc;
   logic [1:0] ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ImmSrc;
   logic [2:0] ALUControl;
   logic       RegWrite;
   logic       IllegalInstr;

   modport slave (
      input  op, funct3, funct7b5, Zero, MemReady,
      output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, RegWrite, IllegalInstr
   );

   modport master (
      output op, funct3, funct7b5, Zero, MemReady,
      input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA,
             ALUSrcB, ImmSrc, ALUControl, RegWrite, IllegalInstr
   );
endinterface

// File: rtl/mc_controller.sv
// ---------------------------------------------------------------------------
// mc_controller
//   Multicycle sequencer for an RV32I-subset core (lw, sw, R-type, I-type
//   ALU, beq/bne, jal) sharing one memory port for instructions and data.
//   A Moore FSM walks each instruction through FETCH/DECODE/... and drives
//   the shared-ALU datapath controls; fetch, load and store wait on MemReady.
//   Parameters:
//     SUPPORT_BNE  1: funct3[0]=1 branches on !Zero; 0: all branches are beq
//   Ports:
//     clk    rising-edge clock
//     reset  asynchronous, active-high; returns the FSM to FETCH
//     bus    mc_controller_if.slave (instruction fields, Zero, MemReady in;
//            datapath controls out)
// ---------------------------------------------------------------------------
module mc_controller #(
   parameter bit SUPPORT_BNE = 1'b1
) (
   input logic           clk,
   input logic           reset,
   mc_controller_if.slave bus
);

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_MEMADR,
      S_MEMREAD,
      S_MEMWB,
      S_MEMWRITE,
      S_EXECR,
      S_EXECI,
      S_ALUWB,
      S_BRANCH,
      S_JAL
   } state_t;

   typedef enum logic [1:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_FUNCT
   } alu_mode_t;

   // State-only part of the control word, registered alongside the state.
   typedef struct packed {
      logic       adr_src;
      logic       mem_write;
      logic [1:0] result_src;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic       reg_write;
      logic       pc_write;   // unconditional PC update (JAL)
      logic       fetch;      // IRWrite/PCWrite gated by MemReady
      logic       branch;     // PCWrite from Zero / funct3[0]
      logic       decode;     // IllegalInstr qualifier
      alu_mode_t  alu_mode;
   } ctrl_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   function automatic ctrl_t ctrl_for(input state_t s);
      ctrl_t c;
      c          = '0;
      c.alu_mode = ALU_ADD;
      case (s)
         S_FETCH: begin
            c.fetch      = 1'b1;
            c.alu_src_a  = 2'b00;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
         S_DECODE: begin
            c.decode    = 1'b1;
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b01;
         end
         S_MEMADR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
         end
         S_MEMREAD: begin
            c.adr_src = 1'b1;
         end
         S_MEMWB: begin
            c.result_src = 2'b01;
            c.reg_write  = 1'b1;
         end
         S_MEMWRITE: begin
            c.adr_src   = 1'b1;
            c.mem_write = 1'b1;
         end
         S_EXECR: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b00;
            c.alu_mode  = ALU_FUNCT;
         end
         S_EXECI: begin
            c.alu_src_a = 2'b10;
            c.alu_src_b = 2'b01;
            c.alu_mode  = ALU_FUNCT;
         end
         S_ALUWB: begin
            c.result_src = 2'b00;
            c.reg_write  = 1'b1;
         end
         S_BRANCH: begin
            c.branch     = 1'b1;
            c.alu_src_a  = 2'b10;
            c.alu_src_b  = 2'b00;
            c.alu_mode   = ALU_SUB;
         end
         S_JAL: begin
            c.pc_write  = 1'b1;
            c.alu_src_a = 2'b01;
            c.alu_src_b = 2'b10;
         end
         default: begin
            c.fetch      = 1'b1;
            c.alu_src_b  = 2'b10;
            c.result_src = 2'b10;
         end
      endcase
      return c;
   endfunction

   state_t state_q, state_d;
   ctrl_t  ctrl_q,  ctrl_d;
   logic   op_legal;
   logic   branch_take;
   logic [2:0] alu_funct;

   always_comb begin
      op_legal = 1'b0;
      case (bus.op)
         OP_LOAD, OP_STORE, OP_RTYPE, OP_ITYPE, OP_BRANCH, OP_JAL: op_legal = 1'b1;
         default: op_legal = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_FETCH:    if (bus.MemReady) state_d = S_DECODE;
         S_DECODE: begin
            case (bus.op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECR;
               OP_ITYPE:          state_d = S_EXECI;
               OP_BRANCH:         state_d = S_BRANCH;
               OP_JAL:            state_d = S_JAL;
               default:           state_d = S_FETCH;
            endcase
         end
         S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:  if (bus.MemReady) state_d = S_MEMWB;
         S_MEMWB:    state_d = S_FETCH;
         S_MEMWRITE: if (bus.MemReady) state_d = S_FETCH;
         S_EXECR:    state_d = S_ALUWB;
         S_EXECI:    state_d = S_ALUWB;
         S_ALUWB:    state_d = S_FETCH;
         S_BRANCH:   state_d = S_FETCH;
         S_JAL:      state_d = S_ALUWB;
         default:    state_d = S_FETCH;
      endcase
      ctrl_d = ctrl_for(state_d);
   end

   // Control word is registered with the state so that state-only outputs
   // come straight from flops; only the MemReady/Zero gating and the
   // ImmSrc/ALUControl decode remain combinational.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
         ctrl_q  <= ctrl_for(S_FETCH);
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
      end
   end

   always_comb begin
      alu_funct = 3'b000;
      case (bus.funct3)
         3'b000:  alu_funct = (bus.op[5] & bus.funct7b5) ? 3'b001 : 3'b000;
         3'b010:  alu_funct = 3'b101;
         3'b110:  alu_funct = 3'b011;
         3'b111:  alu_funct = 3'b010;
         default: alu_funct = 3'b000;
      endcase
   end

   assign branch_take = bus.Zero ^ (SUPPORT_BNE & bus.funct3[0]);

   always_comb begin
      bus.AdrSrc    = ctrl_q.adr_src;
      bus.ResultSrc = ctrl_q.result_src;
      bus.ALUSrcA   = ctrl_q.alu_src_a;
      bus.ALUSrcB   = ctrl_q.alu_src_b;

      case (ctrl_q.alu_mode)
         ALU_SUB:   bus.ALUControl = 3'b001;
         ALU_FUNCT: bus.ALUControl = alu_funct;
         default:   bus.ALUControl = 3'b000;
      endcase

      case (bus.op)
         OP_STORE:  bus.ImmSrc = 2'b01;
         OP_BRANCH: bus.ImmSrc = 2'b10;
         OP_JAL:    bus.ImmSrc = 2'b11;
         default:   bus.ImmSrc = 2'b00;
      endcase

      // Write enables are held low for as long as reset is asserted.
      bus.IRWrite      = ~reset & ctrl_q.fetch & bus.MemReady;
      bus.PCWrite      = ~reset & ((ctrl_q.fetch & bus.MemReady) |
                                   ctrl_q.pc_write |
                                   (ctrl_q.branch & branch_take));
      bus.MemWrite     = ~reset & ctrl_q.mem_write;
      bus.RegWrite     = ~reset & ctrl_q.reg_write;
      bus.IllegalInstr = ~reset & ctrl_q.decode & ~op_legal;
   end

endmodule

// File: tb/tb_mc_controller.sv
// ---------------------------------------------------------------------------
// tb_mc_controller
//   Directed bench for mc_controller. The driver applies one input vector per
//   cycle and queues the hand-computed control word for that cycle; the
//   monitor samples the outputs on the falling edge and compares.
//   Control word layout: {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc,
//   ALUSrcA, ALUSrcB, ImmSrc, ALUControl, RegWrite, IllegalInstr}.
// ---------------------------------------------------------------------------
module tb_mc_controller;

   localparam logic [6:0] LW  = 7'b0000011;
   localparam logic [6:0] SW  = 7'b0100011;
   localparam logic [6:0] RT  = 7'b0110011;
   localparam logic [6:0] IT  = 7'b0010011;
   localparam logic [6:0] BR  = 7'b1100011;
   localparam logic [6:0] JL  = 7'b1101111;
   localparam logic [6:0] BAD = 7'b1111111;

   typedef struct {
      string       name;
      logic [16:0] v;
   } exp_t;

   logic clk;
   logic reset;
   exp_t sbq[$];
   int unsigned n_tests;
   int unsigned n_fail;
   logic [16:0] act;

   mc_controller_if bus ();

   mc_controller #(.SUPPORT_BNE(1'b1)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite,
                 bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ImmSrc,
                 bus.ALUControl, bus.RegWrite, bus.IllegalInstr};

   function automatic logic [16:0] mk(input logic pcw, input logic adr,
                                      input logic mw, input logic irw,
                                      input logic [1:0] rs, input logic [1:0] a,
                                      input logic [1:0] b, input logic [1:0] imm,
                                      input logic [2:0] alu, input logic rw,
                                      input logic ill);
      return {pcw, adr, mw, irw, rs, a, b, imm, alu, rw, ill};
   endfunction

   task automatic cyc(input string nm, input logic rst, input logic [6:0] o,
                      input logic [2:0] f3, input logic f7, input logic z,
                      input logic mr, input logic [16:0] e);
      exp_t x;
      @(posedge clk);
      #1;
      reset        = rst;
      bus.op       = o;
      bus.funct3   = f3;
      bus.funct7b5 = f7;
      bus.Zero     = z;
      bus.MemReady = mr;
      x.name = nm;
      x.v    = e;
      sbq.push_back(x);
   endtask

   // Monitor / scoreboard
   initial begin
      exp_t e;
      n_tests = 0;
      n_fail  = 0;
      forever begin
         @(negedge clk);
         if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_tests++;
            if (act !== e.v) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b", e.name, act, e.v);
            end
         end
      end
   end

   // Stimulus
   initial begin
      reset        = 1'b1;
      bus.op       = LW;
      bus.funct3   = 3'b000;
      bus.funct7b5 = 1'b0;
      bus.Zero     = 1'b0;
      bus.MemReady = 1'b1;

      cyc("reset",      1, LW, 3'b000, 0, 0, 1, mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      // lw with one wait in MEMREAD
      cyc("lw_fetch",   0, LW, 3'b010, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      cyc("lw_decode",  0, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      cyc("lw_memadr",  0, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
      cyc("lw_mr_wait", 0, LW, 3'b010, 0, 0, 0, mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
      cyc("lw_memread", 0, LW, 3'b010, 0, 0, 1, mk(0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
      cyc("lw_memwb",   0, LW, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b01,2'b00,2'b00,2'b00,3'b000,1,0));
      // fetch wait, then sw with MemReady low in DECODE/MEMADR (ignored) and 3 waits
      cyc("f_wait",     0, SW, 3'b010, 0, 0, 0, mk(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
      cyc("sw_fetch",   0, SW, 3'b010, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
      cyc("sw_decode",  0, SW, 3'b010, 0, 0, 0, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
      cyc("sw_memadr",  0, SW, 3'b010, 0, 0, 0, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
      for (int i = 0; i < 3; i++)
         cyc("sw_mw_wait", 0, SW, 3'b010, 0, 0, 0, mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
      cyc("sw_mw_done", 0, SW, 3'b010, 0, 0, 1, mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
      // R-type sub
      cyc("r_fetch",    0, RT, 3'b000, 1, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      cyc("r_decode",   0, RT, 3'b000, 1, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      cyc("r_exec_sub", 0, RT, 3'b000, 1, 0, 1, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
      cyc("r_aluwb",    0, RT, 3'b000, 1, 0, 1, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
      // I-type with funct7b5=1 stays add
      cyc("i_fetch",    0, IT, 3'b000, 1, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      cyc("i_decode",   0, IT, 3'b000, 1, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      cyc("i_exec_add", 0, IT, 3'b000, 1, 0, 1, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
      cyc("i_aluwb",    0, IT, 3'b000, 1, 0, 1, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
      // R-type slt
      cyc("slt_fetch",  0, RT, 3'b010, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      cyc("slt_decode", 0, RT, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
      cyc("slt_exec",   0, RT, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0,0));
      cyc("slt_aluwb",  0, RT, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));
      // beq taken
      cyc("beq_fetch",  0, BR, 3'b000, 0, 1, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
      cyc("beq_decode", 0, BR, 3'b000, 0, 1, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
      cyc("beq_taken",  0, BR, 3'b000, 0, 1, 1, mk(1,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
      // bne with Zero=1: not taken
      cyc("bne_fetch",  0, BR, 3'b001, 0, 1, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
      cyc("bne_decode", 0, BR, 3'b001, 0, 1, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
      cyc("bne_z1",     0, BR, 3'b001, 0, 1, 1, mk(0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
      // bne with Zero=0: taken
      cyc("bne_fetch2", 0, BR, 3'b001, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
      cyc("bne_decode2",0, BR, 3'b001, 0, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
      cyc("bne_z0",     0, BR, 3'b001, 0, 0, 1, mk(1,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,0,0));
      // jal
      cyc("jal_fetch",  0, JL, 3'b000, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b11,3'b000,0,0));
      cyc("jal_decode", 0, JL, 3'b000, 0, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b11,3'b000,0,0));
      cyc("jal_exec",   0, JL, 3'b000, 0, 0, 1, mk(1,0,0,0,2'b00,2'b01,2'b10,2'b11,3'b000,0,0));
      cyc("jal_aluwb",  0, JL, 3'b000, 0, 0, 1, mk(0,0,0,0,2'b00,2'b00,2'b00,2'b11,3'b000,1,0));
      // illegal opcode
      cyc("ill_fetch",  0, BAD, 3'b000, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      cyc("ill_decode", 0, BAD, 3'b000, 0, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1));
      cyc("ill_back_f", 0, BAD, 3'b000, 0, 0, 0, mk(0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
      // reset asserted mid-MEMWRITE, between clock edges
      cyc("sw2_fetch",  0, SW, 3'b010, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
      cyc("sw2_decode", 0, SW, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
      cyc("sw2_memadr", 0, SW, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
      cyc("sw2_mw",     0, SW, 3'b010, 0, 0, 0, mk(0,1,1,0,2'b00,2'b00,2'b00,2'b01,3'b000,0,0));
      cyc("rst_async",  1, SW, 3'b010, 0, 0, 0, mk(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
      cyc("rst_hold",   1, SW, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
      cyc("rst_rel_f",  0, SW, 3'b010, 0, 0, 1, mk(1,0,0,1,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
      cyc("rst_rel_d",  0, SW, 3'b010, 0, 0, 1, mk(0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));

      for (int i = 0; i < 10 && sbq.size() > 0; i++) @(negedge clk);
      #1;
      if (sbq.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d entries left, expected 0", sbq.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
